// File: rtl/battousai_load_unit.sv
// Load unit for the multicycle RISC-V datapath: one memory read per load, lane extract and sign/zero extend.
// Optional read watchdog enabled by defining LOAD_TIMEOUT_EN (MAX_WAIT WAIT cycles without mem_ready).
module battousai_load_unit #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic [63:0] eff_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic [63:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, FORMAT, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  funct3;
  logic [2:0]  addr_lo;
  logic [63:0] rdata;
  logic        accept;
  logic        bad_access;
  logic        timeout;
  logic        unused_instr;

  if (2 ** CNT_W <= MAX_WAIT) begin : g_bad_cfg
    $error("CNT_W too narrow for MAX_WAIT");
  end

  assign unused_instr = ^{instr[31:15], instr[11:7]};
  assign accept       = (state == IDLE) && start && (instr[6:0] == 7'd3);

  // Alignment is checked before FORMAT, so a single byte-granular shift lands every lane at bit 0.
  function automatic logic [63:0] format_lane(input logic [63:0] rd,
                                              input logic [2:0]  f3,
                                              input logic [2:0]  a);
    logic [63:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    shifted = rd >> {a, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    w = shifted[31:0];
    case (f3)
      3'd0:    format_lane = {{56{b[7]}}, b};
      3'd1:    format_lane = {{48{h[15]}}, h};
      3'd2:    format_lane = {{32{w[31]}}, w};
      3'd4:    format_lane = {56'd0, b};
      3'd5:    format_lane = {48'd0, h};
      3'd6:    format_lane = {32'd0, w};
      default: format_lane = rd;
    endcase
  endfunction

  always_comb begin
    bad_access = 1'b0;
    case (funct3)
      3'd1, 3'd5: bad_access = addr_lo[0];
      3'd2, 3'd6: bad_access = |addr_lo[1:0];
      3'd3:       bad_access = |addr_lo;
      3'd7:       bad_access = 1'b1;
      default:    bad_access = 1'b0;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (state == WAIT) && !mem_ready && (wait_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT || mem_ready || timeout) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = CHECK;
      end
      CHECK:  state_next = bad_access ? DONE : REQ;
      REQ: begin
        mem_rd     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        mem_rd = 1'b1;
        if (mem_ready)    state_next = FORMAT;
        else if (timeout) state_next = DONE;
      end
      FORMAT: state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      addr_lo   <= '0;
      funct3    <= '0;
      rdata     <= '0;
      load_data <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr <= {eff_addr[63:3], 3'b000};
        addr_lo  <= eff_addr[2:0];
        funct3   <= instr[14:12];
        err      <= 1'b0;
      end
      if ((state == CHECK && bad_access) || timeout) begin
        err       <= 1'b1;
        load_data <= '0;
      end
      if (state == WAIT && mem_ready) rdata <= mem_rdata;
      if (state == FORMAT) load_data <= format_lane(rdata, funct3, addr_lo);
    end
  end

endmodule
